// File: rtl/sha2_msg_sched.sv
// SHA-2 message schedule: loads a 16-word block and streams W[0..ROUNDS-1]
// from a shifting 16-word window, one word per consumer handshake.
module sha2_msg_sched #(
  parameter  int SHA512 = 0,
  localparam int WORD_W = (SHA512 != 0) ? 64 : 32,
  localparam int ROUNDS = (SHA512 != 0) ? 80 : 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  block_valid,
  output logic                  block_ready,
  input  logic [16*WORD_W-1:0]  block,
  input  logic                  abort,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [WORD_W-1:0]     w_data,
  output logic [6:0]            w_round,
  output logic                  w_last
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

  state_e            state_q;
  logic [6:0]        round_q;
  logic [WORD_W-1:0] win_q [16];
  logic [WORD_W-1:0] next_word;
  logic              adv;
  logic              final_hs;
  logic              load;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                             input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    if (SHA512 != 0) return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    else             return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    if (SHA512 != 0) return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    else             return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign next_word = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  assign w_valid  = (state_q == RUN);
  assign w_last   = w_valid && (round_q == LAST_ROUND);
  assign w_round  = round_q;
  assign w_data   = win_q[0];
  assign adv      = w_valid && w_ready;
  assign final_hs = adv && w_last;

  // Ready in the final-word cycle lets the next block load with no bubble.
  assign block_ready = !reset && !abort && (!w_valid || final_hs);
  assign load        = block_valid && block_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      round_q <= '0;
      for (int unsigned i = 0; i < 16; i++) win_q[i] <= '0;
    end else if (abort) begin
      state_q <= IDLE;
      round_q <= '0;
    end else if (load) begin
      state_q <= RUN;
      round_q <= '0;
      for (int unsigned i = 0; i < 16; i++)
        win_q[i] <= block[WORD_W*(15-i) +: WORD_W];
    end else if (adv) begin
      for (int unsigned i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
      win_q[15] <= next_word;
      if (w_last) begin
        state_q <= IDLE;
        round_q <= '0;
      end else begin
        round_q <= round_q + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_sha2_msg_sched.sv
// Scoreboard bench for sha2_msg_sched: SHA-256 and SHA-512 instances checked
// against a reference schedule computed from the block words.
module tb_sha2_msg_sched;

  typedef struct {
    logic [63:0] data;
    int          rnd;
    bit          last;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic abort = 1'b0;

  logic          bv256 = 1'b0, wr256 = 1'b0;
  logic          br256, wv256, wl256;
  logic [511:0]  blk256 = '0;
  logic [31:0]   wd256;
  logic [6:0]    wrd256;

  logic          bv512 = 1'b0, wr512 = 1'b0;
  logic          br512, wv512, wl512;
  logic [1023:0] blk512 = '0;
  logic [63:0]   wd512;
  logic [6:0]    wrd512;

  int n_vec = 0;
  int n_err = 0;
  exp_t sb256[$];
  exp_t sb512[$];

  logic [511:0]  ABC256 = {32'h61626380, 448'h0, 32'h00000018};
  logic [1023:0] ABC512 = {64'h6162638000000000, 896'h0, 64'h18};

  always #5 clk = ~clk;

  sha2_msg_sched #(.SHA512(0)) u256 (
    .clk(clk), .reset(reset), .block_valid(bv256), .block_ready(br256),
    .block(blk256), .abort(abort), .w_valid(wv256), .w_ready(wr256),
    .w_data(wd256), .w_round(wrd256), .w_last(wl256)
  );

  sha2_msg_sched #(.SHA512(1)) u512 (
    .clk(clk), .reset(reset), .block_valid(bv512), .block_ready(br512),
    .block(blk512), .abort(abort), .w_valid(wv512), .w_ready(wr512),
    .w_data(wd512), .w_round(wrd512), .w_last(wl512)
  );

  function automatic logic [31:0] r32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] r64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  task automatic push256(input logic [511:0] blk);
    logic [31:0] w [64];
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (r32(w[t-2], 17) ^ r32(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (r32(w[t-15], 7) ^ r32(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int t = 0; t < 64; t++)
      sb256.push_back('{data: {32'h0, w[t]}, rnd: t, last: (t == 63)});
  endtask

  task automatic push512(input logic [1023:0] blk);
    logic [63:0] w [80];
    for (int t = 0; t < 16; t++) w[t] = blk[1023-64*t -: 64];
    for (int t = 16; t < 80; t++)
      w[t] = (r64(w[t-2], 19) ^ r64(w[t-2], 61) ^ (w[t-2] >> 6)) + w[t-7]
           + (r64(w[t-15], 1) ^ r64(w[t-15], 8) ^ (w[t-15] >> 7)) + w[t-16];
    for (int t = 0; t < 80; t++)
      sb512.push_back('{data: w[t], rnd: t, last: (t == 79)});
  endtask

  // Entered and left at posedge+1; inputs drive the next edge, outputs sampled mid-cycle.
  task automatic cyc256(input bit bv, input bit wr, output bit acc, output bit hs,
                        output bit v, output bit br, output logic [31:0] d,
                        output logic [6:0] r, output bit l);
    bv256 = bv; wr256 = wr;
    #1;
    br = br256; v = wv256; acc = bv && br256; hs = wv256 && wr;
    d = wd256; r = wrd256; l = wl256;
    @(posedge clk); #1;
  endtask

  task automatic cyc512(input bit bv, input bit wr, output bit acc, output bit hs,
                        output bit v, output logic [63:0] d, output logic [6:0] r,
                        output bit l);
    bv512 = bv; wr512 = wr;
    #1;
    v = wv512; acc = bv && br512; hs = wv512 && wr;
    d = wd512; r = wrd512; l = wl512;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #2;
    n_vec++; if (wv256 !== 1'b0) begin n_err++; $display("FAIL rst_wvalid256: got %b want 0", wv256); end
    n_vec++; if (wrd256 !== 7'd0) begin n_err++; $display("FAIL rst_round256: got %0d want 0", wrd256); end
    n_vec++; if (wl256 !== 1'b0) begin n_err++; $display("FAIL rst_last256: got %b want 0", wl256); end
    n_vec++; if (wd256 !== 32'h0) begin n_err++; $display("FAIL rst_data256: got %h want 0", wd256); end
    n_vec++; if (br256 !== 1'b0) begin n_err++; $display("FAIL rst_bready256: got %b want 0", br256); end
    n_vec++; if (wd512 !== 64'h0 || wv512 !== 1'b0 || br512 !== 1'b0) begin
      n_err++; $display("FAIL rst_512: got data %h valid %b ready %b want 0/0/0", wd512, wv512, br512); end
    reset = 1'b0;
    @(posedge clk); #2;
    n_vec++; if (br256 !== 1'b1) begin n_err++; $display("FAIL rst_release256: bready got %b want 1", br256); end
    n_vec++; if (br512 !== 1'b1) begin n_err++; $display("FAIL rst_release512: bready got %b want 1", br512); end
    @(posedge clk); #1;
  endtask

  task automatic test_abc256();
    bit acc, hs, v, br, l, got;
    logic [31:0] d; logic [6:0] r; exp_t e; int nhs;
    got = 0; nhs = 0;
    blk256 = ABC256;
    for (int i = 0; i < 5 && !got; i++) begin
      cyc256(1, 1, acc, hs, v, br, d, r, l);
      if (acc) begin got = 1; push256(ABC256); end
    end
    n_vec++; if (!got) begin n_err++; $display("FAIL abc_accept: accepted %b want 1", got); end
    for (int i = 0; i < 200 && sb256.size() > 0; i++) begin
      cyc256(0, 1, acc, hs, v, br, d, r, l);
      if (i == 0) begin
        n_vec++; if (v !== 1'b1 || r !== 7'd0) begin n_err++; $display("FAIL abc_latency: valid %b round %0d want 1/0", v, r); end
      end
      if (hs) begin
        e = sb256.pop_front(); nhs++;
        n_vec++; if (d !== e.data[31:0] || r !== 7'(e.rnd) || l !== e.last) begin
          n_err++; $display("FAIL abc_word: got %h/%0d/%b want %h/%0d/%b", d, r, l, e.data[31:0], e.rnd, e.last); end
        if (r == 7'd0)  begin n_vec++; if (d !== 32'h61626380) begin n_err++; $display("FAIL abc_w0: got %h want 61626380", d); end end
        if (r == 7'd15) begin n_vec++; if (d !== 32'h00000018) begin n_err++; $display("FAIL abc_w15: got %h want 00000018", d); end end
        if (r == 7'd16) begin n_vec++; if (d !== 32'h61626380) begin n_err++; $display("FAIL abc_w16: got %h want 61626380", d); end end
        if (r == 7'd17) begin n_vec++; if (d !== 32'h000F0000) begin n_err++; $display("FAIL abc_w17: got %h want 000f0000", d); end end
      end
    end
    n_vec++; if (nhs != 64) begin n_err++; $display("FAIL abc_count: got %0d handshakes want 64", nhs); end
    cyc256(0, 1, acc, hs, v, br, d, r, l);
    n_vec++; if (v !== 1'b0 || r !== 7'd0 || l !== 1'b0) begin
      n_err++; $display("FAIL abc_idle: valid %b round %0d last %b want 0/0/0", v, r, l); end
    sb256.delete();
  endtask

  task automatic test_backpressure();
    bit acc, hs, v, br, l, got, wr;
    logic [31:0] d; logic [6:0] r; exp_t e; int nhs;
    got = 0; nhs = 0;
    blk256 = ABC256;
    for (int i = 0; i < 5 && !got; i++) begin
      cyc256(1, 0, acc, hs, v, br, d, r, l);
      if (acc) begin got = 1; push256(ABC256); end
    end
    n_vec++; if (!got) begin n_err++; $display("FAIL bp_accept: accepted %b want 1", got); end
    for (int i = 0; i < 1000 && sb256.size() > 0; i++) begin
      wr = ($urandom_range(0, 1) == 1);
      cyc256(0, wr, acc, hs, v, br, d, r, l);
      if (v && !wr) begin
        n_vec++; if (d !== sb256[0].data[31:0] || r !== 7'(sb256[0].rnd)) begin
          n_err++; $display("FAIL bp_stall: got %h/%0d want %h/%0d", d, r, sb256[0].data[31:0], sb256[0].rnd); end
      end
      if (hs) begin
        e = sb256.pop_front(); nhs++;
        n_vec++; if (d !== e.data[31:0] || r !== 7'(e.rnd) || l !== e.last) begin
          n_err++; $display("FAIL bp_word: got %h/%0d/%b want %h/%0d/%b", d, r, l, e.data[31:0], e.rnd, e.last); end
      end
    end
    n_vec++; if (nhs != 64) begin n_err++; $display("FAIL bp_count: got %0d handshakes want 64", nhs); end
    sb256.delete();
  endtask

  task automatic test_back_to_back();
    bit acc, hs, v, br, l, bv;
    logic [31:0] d; logic [6:0] r; exp_t e; int nhs, nacc;
    logic [511:0] blkb;
    for (int k = 0; k < 16; k++) blkb[32*k +: 32] = $urandom;
    nhs = 0; nacc = 0; bv = 1;
    blk256 = ABC256;
    for (int i = 0; i < 300 && (nacc < 2 || sb256.size() > 0); i++) begin
      cyc256(bv, 1, acc, hs, v, br, d, r, l);
      if (nhs > 0 && nhs < 128) begin
        n_vec++; if (v !== 1'b1) begin n_err++; $display("FAIL b2b_gap: valid %b at handshake %0d want 1", v, nhs); end
      end
      if (v && !l) begin
        n_vec++; if (br !== 1'b0) begin n_err++; $display("FAIL b2b_ready_mid: bready %b at round %0d want 0", br, r); end
      end
      if (acc) begin
        nacc++;
        if (nacc == 2) begin
          n_vec++; if (!(hs && l) || r !== 7'd63) begin
            n_err++; $display("FAIL b2b_ready_final: accept at round %0d last %b want 63/1", r, l); end
          bv = 0;
        end
        push256(blk256);
        blk256 = blkb;
      end
      if (hs) begin
        e = sb256.pop_front(); nhs++;
        n_vec++; if (d !== e.data[31:0] || r !== 7'(e.rnd) || l !== e.last) begin
          n_err++; $display("FAIL b2b_word: got %h/%0d/%b want %h/%0d/%b", d, r, l, e.data[31:0], e.rnd, e.last); end
      end
    end
    n_vec++; if (nhs != 128 || nacc != 2) begin
      n_err++; $display("FAIL b2b_count: got %0d words %0d blocks want 128/2", nhs, nacc); end
    sb256.delete();
  endtask

  task automatic test_abort();
    bit acc, hs, v, br, l, got;
    logic [31:0] d; logic [6:0] r; exp_t e; int nhs;
    got = 0; nhs = 0;
    blk256 = ABC256;
    for (int i = 0; i < 5 && !got; i++) begin
      cyc256(1, 1, acc, hs, v, br, d, r, l);
      if (acc) got = 1;
    end
    for (int i = 0; i < 100 && nhs < 20; i++) begin
      cyc256(0, 1, acc, hs, v, br, d, r, l);
      if (hs) nhs++;
    end
    n_vec++; if (nhs != 20) begin n_err++; $display("FAIL abort_setup: got %0d handshakes want 20", nhs); end
    abort = 1'b1;
    cyc256(1, 1, acc, hs, v, br, d, r, l);
    abort = 1'b0;
    n_vec++; if (br !== 1'b0 || r !== 7'd20) begin
      n_err++; $display("FAIL abort_cycle: bready %b round %0d want 0/20", br, r); end
    cyc256(1, 1, acc, hs, v, br, d, r, l);
    n_vec++; if (v !== 1'b0 || r !== 7'd0 || br !== 1'b1) begin
      n_err++; $display("FAIL abort_after: valid %b round %0d bready %b want 0/0/1", v, r, br); end
    if (acc) push256(ABC256);
    nhs = 0;
    for (int i = 0; i < 200 && sb256.size() > 0; i++) begin
      cyc256(0, 1, acc, hs, v, br, d, r, l);
      if (hs) begin
        e = sb256.pop_front(); nhs++;
        n_vec++; if (d !== e.data[31:0] || r !== 7'(e.rnd) || l !== e.last) begin
          n_err++; $display("FAIL abort_word: got %h/%0d/%b want %h/%0d/%b", d, r, l, e.data[31:0], e.rnd, e.last); end
      end
    end
    n_vec++; if (nhs != 64) begin n_err++; $display("FAIL abort_restart: got %0d handshakes want 64", nhs); end
    sb256.delete();
  endtask

  task automatic test_reset_mid();
    bit acc, hs, v, br, l, got;
    logic [31:0] d; logic [6:0] r; int nhs;
    got = 0; nhs = 0;
    blk256 = ABC256;
    for (int i = 0; i < 5 && !got; i++) begin
      cyc256(1, 1, acc, hs, v, br, d, r, l);
      if (acc) got = 1;
    end
    for (int i = 0; i < 100 && nhs < 30; i++) begin
      cyc256(0, 1, acc, hs, v, br, d, r, l);
      if (hs) nhs++;
    end
    reset = 1'b1;
    cyc256(1, 1, acc, hs, v, br, d, r, l);
    reset = 1'b0;
    n_vec++; if (br !== 1'b0 || r !== 7'd30) begin
      n_err++; $display("FAIL rstmid_cycle: bready %b round %0d want 0/30", br, r); end
    cyc256(0, 0, acc, hs, v, br, d, r, l);
    n_vec++; if (v !== 1'b0 || r !== 7'd0 || l !== 1'b0 || d !== 32'h0 || br !== 1'b1) begin
      n_err++; $display("FAIL rstmid_after: valid %b round %0d last %b data %h bready %b want 0/0/0/0/1", v, r, l, d, br); end
  endtask

  task automatic test_abc512();
    bit acc, hs, v, l, got;
    logic [63:0] d; logic [6:0] r; exp_t e; int nhs;
    got = 0; nhs = 0;
    blk512 = ABC512;
    for (int i = 0; i < 5 && !got; i++) begin
      cyc512(1, 1, acc, hs, v, d, r, l);
      if (acc) begin got = 1; push512(ABC512); end
    end
    n_vec++; if (!got) begin n_err++; $display("FAIL sha512_accept: accepted %b want 1", got); end
    for (int i = 0; i < 200 && sb512.size() > 0; i++) begin
      cyc512(0, 1, acc, hs, v, d, r, l);
      if (hs) begin
        e = sb512.pop_front(); nhs++;
        n_vec++; if (d !== e.data || r !== 7'(e.rnd) || l !== e.last) begin
          n_err++; $display("FAIL sha512_word: got %h/%0d/%b want %h/%0d/%b", d, r, l, e.data, e.rnd, e.last); end
        if (r == 7'd16) begin n_vec++; if (d !== 64'h6162638000000000) begin n_err++; $display("FAIL sha512_w16: got %h want 6162638000000000", d); end end
        if (r == 7'd17) begin n_vec++; if (d !== 64'h00030000000000C0) begin n_err++; $display("FAIL sha512_w17: got %h want 00030000000000c0", d); end end
        if (l) begin n_vec++; if (r !== 7'd79) begin n_err++; $display("FAIL sha512_last: last at round %0d want 79", r); end end
      end
    end
    n_vec++; if (nhs != 80) begin n_err++; $display("FAIL sha512_count: got %0d handshakes want 80", nhs); end
    sb512.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_abc256();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_abc512();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
